seg7_scan_driver: RTL and testbench

//  Multiplexed N-digit 7-segment display driver: latches a packed BCD/hex word, time-multiplexes digits onto one shared

---
 rtl/seg7_pkg.sv | 44 ++++
 rtl/seg7_glyph_rom.sv | 10 +
 rtl/seg7_scan_driver.sv | 132 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: active-high 7-segment glyph constants and nibble decode helper
package seg7_pkg;
  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h1F;
  localparam logic [6:0] SEG_C     = 7'h4E;
  localparam logic [6:0] SEG_D     = 7'h3D;
  localparam logic [6:0] SEG_E     = 7'h4F;
  localparam logic [6:0] SEG_F     = 7'h47;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_ALL   = 7'h7F;

  function automatic logic [6:0] nibble_to_seg(input logic [3:0] nibble, input logic hex_en);
    logic [6:0] s;
    case (nibble)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      default: s = SEG_F;
    endcase
    return (!hex_en && nibble > 4'd9) ? SEG_BLANK : s;
  endfunction
endpackage

// File: rtl/seg7_glyph_rom.sv
// seg7_glyph_rom: combinational nibble to active-high segment pattern
module seg7_glyph_rom
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_en,
  output logic [6:0] seg
);
  assign seg = nibble_to_seg(nibble, hex_en);
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed N-digit 7-segment driver with blanking, lamp test, dp and blink
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 2,
  parameter int HEX_EN       = 1,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    nRST,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    nLT,
  input  logic                    nRBI,
  input  logic                    nBI,
  output logic [6:0]              nSEG,
  output logic                    nDP,
  output logic [NUM_DIGITS-1:0]   nAN,
  output logic                    frame_tick
);
  localparam int DW = $clog2(REFRESH_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] GUARD    = DW'(GUARD_CYCLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

  logic [DW-1:0]           div_cnt;
  logic [IW-1:0]           idx;
  logic [FW-1:0]           frm_cnt;
  logic                    blink_on;
  logic                    slot_end;
  logic [4*NUM_DIGITS-1:0] sh_val, act_val;
  logic [NUM_DIGITS-1:0]   sh_dp, act_dp, sh_blink, act_blink;
  logic [NUM_DIGITS-1:0]   sup;
  logic                    zero_run;
  logic                    hide;
  logic [3:0]              nib;
  logic [6:0]              glyph;
  logic [6:0]              seg_n;
  logic                    dp_n;
  logic [NUM_DIGITS-1:0]   an_n;

  assign slot_end   = div_cnt == DIV_LAST;
  assign frame_tick = slot_end && idx == IDX_LAST;
  assign nib        = act_val[idx*4 +: 4];

  seg7_glyph_rom u_rom (
    .nibble (nib),
    .hex_en (HEX_EN != 0),
    .seg    (glyph)
  );

  // slot divider and digit index; index advances once per slot
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      div_cnt <= '0;
      idx     <= '0;
    end else if (slot_end) begin
      div_cnt <= '0;
      idx     <= idx == IDX_LAST ? '0 : idx + 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // frame counter flips the blink phase every BLINK_FRAMES frames
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      frm_cnt  <= '0;
      blink_on <= 1'b1;
    end else if (frame_tick) begin
      frm_cnt  <= frm_cnt == FRM_LAST ? '0 : frm_cnt + 1'b1;
      blink_on <= frm_cnt == FRM_LAST ? ~blink_on : blink_on;
    end
  end

  // loads land in shadow; active only changes at frame boundaries so a frame never mixes data
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      sh_val    <= '0;
      sh_dp     <= '0;
      sh_blink  <= '0;
      act_val   <= '0;
      act_dp    <= '0;
      act_blink <= '0;
    end else begin
      if (load) begin
        sh_val   <= value;
        sh_dp    <= dp_in;
        sh_blink <= blink_mask;
      end
      if (frame_tick) begin
        act_val   <= load ? value : sh_val;
        act_dp    <= load ? dp_in : sh_dp;
        act_blink <= load ? blink_mask : sh_blink;
      end
    end
  end

  // leading-zero suppression chain and per-slot output selection by priority
  always_comb begin
    zero_run = 1'b1;
    sup      = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run = zero_run & (act_val[4*i +: 4] == 4'h0);
      sup[i]   = ~nRBI & zero_run;
    end
    hide  = sup[idx] | (act_blink[idx] & ~blink_on);
    seg_n = !nBI ? ~SEG_BLANK : !nLT ? ~SEG_ALL : hide ? ~SEG_BLANK : ~glyph;
    dp_n  = !nBI ? 1'b1 : !nLT ? 1'b0 : hide ? 1'b1 : ~act_dp[idx];
    an_n  = div_cnt >= GUARD ? ~(NUM_DIGITS'(1) << idx) : '1;
  end

  // registered pin drivers
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      nSEG <= 7'h7F;
      nDP  <= 1'b1;
      nAN  <= '1;
    end else begin
      nSEG <= seg_n;
      nDP  <= dp_n;
      nAN  <= an_n;
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: random and directed checks against a cycle-count based display model
module tb_seg7_scan_driver;
  localparam int N  = 4;
  localparam int RD = 4;
  localparam int G  = 1;
  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        nRST = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blink_mask = '0;
  logic        nLT = 1'b1;
  logic        nRBI = 1'b1;
  logic        nBI = 1'b1;
  logic [6:0]  nSEG, seg_dec;
  logic        nDP, dp_dec;
  logic [3:0]  nAN, an_dec;
  logic        frame_tick, tick_dec;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  logic [6:0] glyph_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  int          k, m_div, m_idx;
  logic [15:0] m_sh_val, m_act_val;
  logic [3:0]  m_sh_dp, m_act_dp, m_sh_bm, m_act_bm;
  logic [3:0]  m_nib;
  logic        m_hide;
  logic [6:0]  e_seg, e_seg_dec;
  logic        e_dp, e_tick;
  logic [3:0]  e_an;

  seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .GUARD_CYCLES(G), .HEX_EN(1), .BLINK_FRAMES(BF)) u_hex (
    .clk(clk), .nRST(nRST), .load(load), .value(value), .dp_in(dp_in), .blink_mask(blink_mask),
    .nLT(nLT), .nRBI(nRBI), .nBI(nBI), .nSEG(nSEG), .nDP(nDP), .nAN(nAN), .frame_tick(frame_tick)
  );

  seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .GUARD_CYCLES(G), .HEX_EN(0), .BLINK_FRAMES(BF)) u_dec (
    .clk(clk), .nRST(nRST), .load(load), .value(value), .dp_in(dp_in), .blink_mask(blink_mask),
    .nLT(nLT), .nRBI(nRBI), .nBI(nBI), .nSEG(seg_dec), .nDP(dp_dec), .nAN(an_dec), .frame_tick(tick_dec)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // k = clock edges since reset release; slot, digit and frame follow from plain division
  always @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      k = 0;
      {m_sh_val, m_act_val, m_sh_dp, m_act_dp, m_sh_bm, m_act_bm} = '0;
      e_seg = 7'h7F;
      e_seg_dec = 7'h7F;
      e_dp = 1'b1;
      e_an = 4'hF;
      e_tick = 1'b0;
    end else begin
      m_div  = k % RD;
      m_idx  = (k / RD) % N;
      m_nib  = 4'(m_act_val >> (4 * m_idx));
      m_hide = (!nRBI && m_idx != 0 && (m_act_val >> (4 * m_idx)) == 16'h0) ||
               (m_act_bm[m_idx] && ((k / (RD * N)) / BF) % 2 == 1);
      e_an = (m_div >= G) ? ~(4'b0001 << m_idx) : 4'hF;
      if (!nBI) begin
        e_seg = 7'h7F; e_seg_dec = 7'h7F; e_dp = 1'b1;
      end else if (!nLT) begin
        e_seg = 7'h00; e_seg_dec = 7'h00; e_dp = 1'b0;
      end else if (m_hide) begin
        e_seg = 7'h7F; e_seg_dec = 7'h7F; e_dp = 1'b1;
      end else begin
        e_seg = ~glyph_tab[m_nib];
        e_seg_dec = m_nib > 4'd9 ? 7'h7F : ~glyph_tab[m_nib];
        e_dp = ~m_act_dp[m_idx];
      end
      if (m_div == RD - 1 && m_idx == N - 1) begin
        m_act_val = load ? value : m_sh_val;
        m_act_dp  = load ? dp_in : m_sh_dp;
        m_act_bm  = load ? blink_mask : m_sh_bm;
      end
      if (load) begin
        m_sh_val = value; m_sh_dp = dp_in; m_sh_bm = blink_mask;
      end
      k++;
      e_tick = (k % RD == RD - 1) && ((k / RD) % N == N - 1);
    end
  end

  always @(negedge clk) begin
    check("nAN", nAN, e_an);
    check("nSEG", nSEG, e_seg);
    check("nDP", nDP, e_dp);
    check("frame_tick", frame_tick, e_tick);
    check("dec_nAN", an_dec, e_an);
    check("dec_nSEG", seg_dec, e_seg_dec);
    check("dec_nDP", dp_dec, e_dp);
    check("dec_tick", tick_dec, e_tick);
  end

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bm);
    value = v; dp_in = dp; blink_mask = bm; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_tick;
    int n = 0;
    do begin @(negedge clk); n++; end while (frame_tick !== 1'b1 && n < 64);
    check("tick_seen", frame_tick, 1);
  endtask

  task automatic wait_slot(input int d);
    int n = 0;
    logic [3:0] want;
    want = ~(4'b0001 << d);
    while (nAN !== want && n < 64) begin @(negedge clk); n++; end
    check("slot_anode", nAN, want);
  endtask

  initial begin
    int t0, t1, blanks, r;
    repeat (3) @(negedge clk);
    check("rst_nAN", nAN, 4'hF);
    check("rst_nSEG", nSEG, 7'h7F);
    check("rst_nDP", nDP, 1);
    check("rst_tick", frame_tick, 0);
    nRST = 1'b1;
    @(negedge clk);
    do_load(16'h1234, 4'b0100, 4'b0000);
    wait_tick;
    t0 = cyc;
    @(negedge clk);
    @(negedge clk);
    check("guard_off", nAN, 4'hF);
    wait_slot(0);
    check("d0_glyph4", nSEG, 7'h4C);
    wait_slot(2);
    check("d2_dp", nDP, 0);
    check("d2_glyph2", nSEG, 7'h12);
    wait_tick;
    t1 = cyc;
    check("tick_period", t1 - t0, 16);
    nRBI = 1'b0;
    do_load(16'h0050, 4'b0000, 4'b0000);
    wait_tick;
    wait_slot(1);
    check("rbi_d1", nSEG, 7'h24);
    wait_slot(3);
    check("rbi_d3", nSEG, 7'h7F);
    wait_slot(0);
    check("rbi_d0", nSEG, 7'h01);
    do_load(16'h0000, 4'b0000, 4'b0000);
    wait_tick;
    wait_slot(0);
    check("rbi0_d0", nSEG, 7'h01);
    wait_slot(1);
    check("rbi0_d1", nSEG, 7'h7F);
    nRBI = 1'b1;
    do_load(16'hABCD, 4'b0000, 4'b0000);
    wait_tick;
    wait_slot(0);
    check("hex_d", nSEG, 7'h42);
    check("dec_d", seg_dec, 7'h7F);
    wait_slot(3);
    check("hex_A", nSEG, 7'h08);
    check("dec_A", seg_dec, 7'h7F);
    nLT = 1'b0;
    wait_slot(2);
    check("lt_seg", nSEG, 7'h00);
    check("lt_dp", nDP, 0);
    nBI = 1'b0;
    wait_slot(1);
    check("bi_seg", nSEG, 7'h7F);
    check("bi_dp", nDP, 1);
    nLT = 1'b1;
    nBI = 1'b1;
    wait_tick;
    @(negedge clk);
    do_load(16'h1111, 4'b0000, 4'b0000);
    do_load(16'h2222, 4'b0000, 4'b0000);
    wait_tick;
    wait_slot(0);
    check("last_load", nSEG, 7'h12);
    wait_tick;
    do_load(16'h3333, 4'b0000, 4'b0000);
    wait_slot(0);
    check("load_on_tick", nSEG, 7'h06);
    do_load(16'h8888, 4'b0000, 4'b0001);
    blanks = 0;
    repeat (8) begin
      wait_tick;
      wait_slot(0);
      if (nSEG === 7'h7F) blanks++;
    end
    check("blink_count", blanks, 4);
    repeat (300) begin
      repeat ($urandom_range(0, 6)) @(negedge clk);
      r = $urandom_range(0, 9);
      if (r < 6) do_load(16'($urandom), 4'($urandom), 4'($urandom));
      else if (r == 6) nRBI = ~nRBI;
      else if (r == 7) nLT = $urandom_range(0, 3) != 0;
      else if (r == 8) nBI = $urandom_range(0, 3) != 0;
      else @(negedge clk);
    end
    nLT = 1'b1;
    nBI = 1'b1;
    wait_slot(1);
    @(negedge clk);
    #2 nRST = 1'b0;
    #1;
    check("async_nAN", nAN, 4'hF);
    check("async_nSEG", nSEG, 7'h7F);
    check("async_nDP", nDP, 1);
    @(negedge clk);
    nRST = 1'b1;
    t0 = 0;
    while (nAN === 4'hF && t0 < 16) begin @(negedge clk); t0++; end
    check("restart_d0", nAN, 4'b1110);
    repeat (20) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
